sn_popcount_seq: RTL
====================

Name: sn_popcount_seq

Overview:
- Time-multiplexed population counter built around one 4-input sorting-network counter cell.
- Accepts an N_BITS-wide word over a valid/ready handshake, then feeds it through the shared cell one 4-bit group per cycle and accumulates the result.
- Returns the total count over a second valid/ready handshake.
- A per-word mode selects the exact count or the approximate 4:2 compressor count. The block sits between operand buffers and the counter/compressor datapath and owns its sequencing.

Parameters:
- N_BITS, 16, input word width. Must be a multiple of 4 and at least 4.
- G, N_BITS/4, number of 4-bit groups (derived; not overridable).
- CW, $clog2(N_BITS+1), width of the count output and the accumulator.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  input word is available.
- in_ready  out  1  block can accept a word (high only in IDLE).
- in_data  in  N_BITS  word to count.
- in_mode  in  1  0 = exact, 1 = approximate; latched at accept.
- clear  in  1  synchronous abort; ignored in IDLE.
- out_valid  out  1  count result is valid.
- out_ready  in  1  consumer accepts the result.
- out_count  out  CW  accumulated count.
- out_mode  out  1  mode used to produce out_count.
- busy  out  1  high in RUN or DONE.

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- Reset values: state = IDLE, in_ready = 1, out_valid = 0, out_count = 0, out_mode = 0, busy = 0, group index = 0, accumulator = 0, latched word = 0.
- Per-group cell: group i is bits [4i+3:4i], with bit 4i driving input i1. The cell sorts its 4 inputs into A ≥ h1 ≥ h2 ≥ D.
  - Exact value = A + h1 + h2 + D, which equals k, the number of ones in the group (0..4).
  - Approximate value = 2·(h1 & A) + ((h1 ^ A) | h2), which equals min(k,3).
  - The cell is combinational; its value is added to the accumulator in the same cycle.
- FSM, IDLE:
  - in_ready = 1.
  - On in_valid & in_ready: latch in_data and in_mode, clear the accumulator, set index = 0, go to RUN.
- FSM, RUN:
  - in_ready = 0.
  - Each cycle: accumulator += value(group[index]); index++.
  - When index == G-1 after the add, go to DONE.
  - Exactly G RUN cycles per word.
- FSM, DONE:
  - out_valid = 1; out_count = accumulator; out_mode = latched mode.
  - On out_ready: go to IDLE. in_ready rises in the next cycle; there is no same-cycle re-accept.
- Latency: handshake at cycle T → out_valid first high at T+G+1.
- Throughput: one word per G+2 cycles when out_ready is held high.
- Output hold: out_count and out_mode stay stable while out_valid=1 and out_ready=0. In IDLE and RUN, out_count holds its last value but out_valid=0.
- Width: the accumulator never overflows. Maximum is N_BITS (exact) or 3·G (approximate), both ≤ 2^CW−1. The addition is unsigned with no saturation logic.
- clear:
  - In RUN or DONE: go to IDLE next cycle, with out_valid=0, accumulator=0, index=0. No result is produced.
  - clear together with out_ready in DONE: clear wins, and the result counts as dropped.
- rst mid-operation: same effect as clear, plus the reset values above. rst has priority over everything.
- in_valid in RUN or DONE is ignored; the producer must hold in_valid until in_ready.
- in_data and in_mode changes after accept have no effect on the word in flight.

Test Plan:
- Reset, then idle: after rst, in_ready=1, out_valid=0, busy=0, out_count=0.
- Exact count: N_BITS=16, in_data=16'hF0F3, mode 0 → out_valid at T+5, out_count=10, out_mode=0.
- Approximate count: in_data=16'hFFFF, mode 1 → out_count=12 (4 groups × 3). Also in_data=16'h1237, mode 1 → groups 7,3,2,1 give 3+2+1+1 = 7.
- Backpressure: hold out_ready=0 for 5 cycles in DONE → out_count stable, in_ready=0, a new in_valid is ignored. Release → IDLE, then accept.
- Abort: assert clear in RUN cycle 2 → no out_valid. Next word 16'h0001, mode 0 → out_count=1 (no stale accumulator).
- Back-to-back: 3 words with out_ready=1 → accepts spaced G+2 = 6 cycles apart, counts in order, and the per-word mode is preserved on out_mode.

Source files
------------

// File: rtl/sn_popcount_seq.sv
// Purpose: time-multiplexed popcount; one 4-input sorting-network counter cell shared across the 4-bit groups of a word.
// Latency: accept at cycle T -> out_valid first high at T+G+1; one word per G+2 cycles with out_ready held high.
// Backpressure: in_ready only in IDLE; result held stable in DONE until out_ready; clear aborts RUN/DONE.
module sn_popcount_seq #(
  parameter  int N_BITS = 16,
  localparam int G      = N_BITS / 4,
  localparam int CW     = $clog2(N_BITS + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [N_BITS-1:0] in_data,
  input  logic              in_mode,
  input  logic              clear,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CW-1:0]     out_count,
  output logic              out_mode,
  output logic              busy
);

  // Group index width; a single-group word still needs a 1-bit index.
  localparam int IW = (G > 1) ? $clog2(G) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t              state_q, state_d;
  logic [N_BITS-1:0]   word_q, word_d;
  logic                mode_q, mode_d;
  logic [IW-1:0]       idx_q, idx_d;
  logic [CW-1:0]       acc_q, acc_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic                omode_q, omode_d;

  logic [N_BITS-1:0]   word_shifted;
  logic [3:0]          grp;
  logic                s0, s1, s2, s3, t1, t2;
  logic                a_hi, h1, h2, d_lo;
  logic [2:0]          exact_val;
  logic [1:0]          approx_val;
  logic [CW-1:0]       cell_val;
  logic [CW-1:0]       acc_sum;

  // Select the current group; bit 4i of the word feeds cell input i1.
  assign word_shifted = word_q >> {idx_q, 2'b00};
  assign grp          = word_shifted[3:0];

  // Shared counter cell: 5-comparator sorting network on single bits (max = OR, min = AND),
  // giving A >= h1 >= h2 >= D, then the exact sum or the saturating 4:2 compressor value.
  always_comb begin
    s0         = grp[0] | grp[1];
    s1         = grp[0] & grp[1];
    s2         = grp[2] | grp[3];
    s3         = grp[2] & grp[3];
    a_hi       = s0 | s2;
    t1         = s0 & s2;
    t2         = s1 | s3;
    d_lo       = s1 & s3;
    h1         = t1 | t2;
    h2         = t1 & t2;
    exact_val  = {2'b00, a_hi} + {2'b00, h1} + {2'b00, h2} + {2'b00, d_lo};
    approx_val = {h1 & a_hi, (h1 ^ a_hi) | h2};
    cell_val   = mode_q ? CW'(approx_val) : CW'(exact_val);
    acc_sum    = acc_q + cell_val;
  end

  // State and datapath registers; rst overrides everything.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      word_q  <= '0;
      mode_q  <= 1'b0;
      idx_q   <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      omode_q <= 1'b0;
    end else begin
      state_q <= state_d;
      word_q  <= word_d;
      mode_q  <= mode_d;
      idx_q   <= idx_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      omode_q <= omode_d;
    end
  end

  // Next-state and handshake outputs; result registers only load on the final group so
  // out_count/out_mode keep their last value outside DONE.
  always_comb begin
    state_d   = state_q;
    word_d    = word_q;
    mode_d    = mode_q;
    idx_d     = idx_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    omode_d   = omode_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b1;
    case (state_q)
      S_IDLE: begin
        in_ready = 1'b1;
        busy     = 1'b0;
        if (in_valid) begin
          word_d  = in_data;
          mode_d  = in_mode;
          acc_d   = '0;
          idx_d   = '0;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        if (clear) begin
          acc_d   = '0;
          idx_d   = '0;
          state_d = S_IDLE;
        end else begin
          acc_d = acc_sum;
          idx_d = idx_q + IW'(1);
          if (idx_q == IW'(G - 1)) begin
            cnt_d   = acc_sum;
            omode_d = mode_q;
            idx_d   = '0;
            state_d = S_DONE;
          end
        end
      end
      S_DONE: begin
        out_valid = 1'b1;
        if (clear) begin
          acc_d   = '0;
          idx_d   = '0;
          state_d = S_IDLE;
        end else if (out_ready) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign out_count = cnt_q;
  assign out_mode  = omode_q;

endmodule
